poly_driver: RTL

Operand sequencer that feeds the polynomial evaluator over its Go/DataIn serial load interface. It accepts a full operand set (A, B, C, x) in one parallel handshake, then presents each operand on DataIn with a Go press/release pattern. It waits for ResultValid, captures DataResult, and returns the 8-bit result of A·x² + B·x + C. It sits between a host/test controller and the evaluator, replacing manual switch/key entry.

---
 rtl/poly_pkg.sv | 39 +++
 rtl/poly_cycle_counter.sv | 34 +++
 rtl/poly_driver.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/poly_pkg.sv
// ============================================================================
// Module   : poly_pkg
// Brief    : Shared types and defaults for the poly_driver operand sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package poly_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    GO_HI    = 3'd2,
    GO_LO    = 3'd3,
    WAIT_RES = 3'd4
  } state_t;

  typedef logic [1:0] op_idx_t;

  localparam int c_go_high_cycles = 2;
  localparam int c_go_low_cycles  = 2;
  localparam int c_timeout_cycles = 32;

  // Counter width large enough to hold the longest reload value.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction

  function automatic logic [7:0] poly_eval(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic [7:0] x);
    return 8'(a * x * x + b * x + c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/poly_cycle_counter.sv
// ============================================================================
// Module   : poly_cycle_counter
// Brief    : Loadable down-counter with a done flag, saturating at zero.
// Revision : 1.0
// ============================================================================
`default_nettype none

module poly_cycle_counter #(
  parameter int WIDTH = 6
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/poly_driver.sv
// ============================================================================
// Module   : poly_driver
// Brief    : Serial Go/DataIn operand sequencer for the polynomial evaluator.
//            Optional result check enabled by defining POLY_DRIVER_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module poly_driver
  import poly_pkg::*;
#(
  parameter int GO_HIGH_CYCLES = c_go_high_cycles,
  parameter int GO_LOW_CYCLES  = c_go_low_cycles,
  parameter int TIMEOUT_CYCLES = c_timeout_cycles
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       start,
  output logic       ready,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  input  logic [7:0] op_c,
  input  logic [7:0] op_x,
  output logic       Go,
  output logic [7:0] DataIn,
  input  logic       ResultValid,
  input  logic [7:0] DataResult,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       timeout_err,
  output logic       mismatch
);

  localparam int c_cnt_w = cnt_width(GO_HIGH_CYCLES, GO_LOW_CYCLES, TIMEOUT_CYCLES);

  state_t               r_state;
  op_idx_t              r_idx;
  logic [3:0][7:0]      r_ops;
  logic                 r_go;
  logic [7:0]           r_data_in;
  logic [7:0]           r_result;
  logic                 r_result_valid;
  logic                 r_timeout_err;
  logic                 w_accept;
  logic                 w_capture;
  logic                 w_ctr_load;
  logic [c_cnt_w-1:0]   w_ctr_val;
  logic                 w_ctr_done;

  assign w_accept  = start && (r_state == IDLE);
  assign w_capture = (r_state == WAIT_RES) && ResultValid;

  // Counter is reloaded on the cycle that transitions into a timed state.
  always_comb begin
    w_ctr_load = 1'b0;
    w_ctr_val  = '0;
    case (r_state)
      SETUP: begin
        w_ctr_load = 1'b1;
        w_ctr_val  = c_cnt_w'(GO_HIGH_CYCLES - 1);
      end
      GO_HI: begin
        w_ctr_load = w_ctr_done;
        w_ctr_val  = c_cnt_w'(GO_LOW_CYCLES - 1);
      end
      GO_LO: begin
        w_ctr_load = w_ctr_done && (r_idx == 2'd3);
        w_ctr_val  = c_cnt_w'(TIMEOUT_CYCLES - 1);
      end
      default: ;
    endcase
  end

  poly_cycle_counter #(
    .WIDTH (c_cnt_w)
  ) u_counter (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .i_load     (w_ctr_load),
    .i_load_val (w_ctr_val),
    .o_done     (w_ctr_done)
  );

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_state        <= IDLE;
      r_idx          <= '0;
      r_ops          <= '0;
      r_go           <= 1'b0;
      r_data_in      <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_ops         <= {op_x, op_c, op_b, op_a};
            r_idx         <= '0;
            r_data_in     <= op_a;
            r_timeout_err <= 1'b0;
            r_state       <= SETUP;
          end
        end
        SETUP: begin
          r_go    <= 1'b1;
          r_state <= GO_HI;
        end
        GO_HI: begin
          if (w_ctr_done) begin
            r_go    <= 1'b0;
            r_state <= GO_LO;
          end
        end
        GO_LO: begin
          if (w_ctr_done) begin
            if (r_idx == 2'd3) begin
              r_state <= WAIT_RES;
            end else begin
              r_idx     <= r_idx + 2'd1;
              r_data_in <= r_ops[r_idx + 2'd1];
              r_state   <= SETUP;
            end
          end
        end
        WAIT_RES: begin
          if (w_capture) begin
            r_result       <= DataResult;
            r_result_valid <= 1'b1;
            r_state        <= IDLE;
          end else if (w_ctr_done) begin
            r_timeout_err <= 1'b1;
            r_state       <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef POLY_DRIVER_CHECK_EN
  logic [7:0] r_expected;
  logic       r_mismatch;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_expected <= '0;
      r_mismatch <= 1'b0;
    end else if (w_accept) begin
      r_expected <= poly_eval(op_a, op_b, op_c, op_x);
      r_mismatch <= 1'b0;
    end else if (w_capture) begin
      r_mismatch <= (DataResult != r_expected);
    end
  end

  assign mismatch = r_mismatch;
`else
  assign mismatch = 1'b0;
`endif

  assign ready        = (r_state == IDLE);
  assign Go           = r_go;
  assign DataIn       = r_data_in;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign timeout_err  = r_timeout_err;

endmodule

`default_nettype wire
